// File: rtl/hls2x8_acc_pkg.sv
// Shared definitions for the HLS2x8 row accumulator: default widths and the
// output-register state encoding.
package hls2x8_acc_pkg;

  localparam int DIN_W_DEF     = 16;
  localparam int ACC_W_DEF     = 24;
  localparam int DOUT_W_DEF    = 16;
  localparam int N_TERMS_DEF   = 8;
  localparam int N_ROWS_DEF    = 2;

  // Output register occupancy
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } acc_state_e;

endpackage

// File: rtl/hls2x8_row_accum_clip.sv
// Combinational narrowing of the wide row sum to the result width.
// Build switch HLS2X8_ACC_SAT_EN: defined -> saturate and flag ovf,
// undefined -> keep the low bits (wrap) with ovf tied low.
module hls2x8_row_accum_clip
  import hls2x8_acc_pkg::*;
#(
  parameter int ACC_WIDTH  = ACC_W_DEF,
  parameter int DOUT_WIDTH = DOUT_W_DEF
) (
  input  logic signed [ACC_WIDTH-1:0]  acc_in,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         ovf
);

`ifdef HLS2X8_ACC_SAT_EN
  // Returns {ovf, data}; value fits when all bits above the result sign agree
  function automatic logic [DOUT_WIDTH:0] clip_fn(input logic signed [ACC_WIDTH-1:0] v);
    logic [ACC_WIDTH-DOUT_WIDTH:0] hi;
    logic [DOUT_WIDTH:0]           r;
    hi = v[ACC_WIDTH-1:DOUT_WIDTH-1];
    if ((&hi) || !(|hi)) begin
      r = {1'b0, v[DOUT_WIDTH-1:0]};
    end else if (v[ACC_WIDTH-1]) begin
      r = {1'b1, 1'b1, {(DOUT_WIDTH-1){1'b0}}};
    end else begin
      r = {1'b1, 1'b0, {(DOUT_WIDTH-1){1'b1}}};
    end
    return r;
  endfunction
`else
  // Returns {ovf, data}; plain two's complement truncation, never flags
  function automatic logic [DOUT_WIDTH:0] clip_fn(input logic signed [ACC_WIDTH-1:0] v);
    logic [ACC_WIDTH-1:0] u;
    u = v;
    return {1'b0, u[DOUT_WIDTH-1:0]};
  endfunction
`endif

  // Split the packed function result into data and flag
  always_comb begin
    logic [DOUT_WIDTH:0] res;
    res  = clip_fn(acc_in);
    dout = $signed(res[DOUT_WIDTH-1:0]);
    ovf  = res[DOUT_WIDTH];
  end

endmodule

// File: rtl/hls2x8_row_accum.sv
// HLS2x8 row accumulator: sums N_TERMS signed products per row, emits one
// clipped result per row on a valid/ready output tagged with row index and
// end-of-frame flag. Clipping mode is chosen by HLS2X8_ACC_SAT_EN (see the
// clip sub-module). Only the closing term of a row can stall the input.
module hls2x8_row_accum
  import hls2x8_acc_pkg::*;
#(
  parameter int DIN_WIDTH  = DIN_W_DEF,
  parameter int ACC_WIDTH  = ACC_W_DEF,
  parameter int DOUT_WIDTH = DOUT_W_DEF,
  parameter int N_TERMS    = N_TERMS_DEF,
  parameter int N_ROWS     = N_ROWS_DEF
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst,
  input  logic signed [DIN_WIDTH-1:0]   prod_data,
  input  logic                          prod_valid,
  output logic                          prod_ready,
  output logic signed [DOUT_WIDTH-1:0]  sum_data,
  output logic [$clog2(N_ROWS)-1:0]     sum_row,
  output logic                          sum_last,
  output logic                          sum_ovf,
  output logic                          sum_valid,
  input  logic                          sum_ready
);

  localparam int TCW = $clog2(N_TERMS);
  localparam int RW  = $clog2(N_ROWS);

  acc_state_e                  state_q, state_d;
  logic [TCW-1:0]              term_cnt_q, term_cnt_d;
  logic [RW-1:0]               row_cnt_q, row_cnt_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [DOUT_WIDTH-1:0] sum_data_q, sum_data_d;
  logic [RW-1:0]               sum_row_q, sum_row_d;
  logic                        sum_last_q, sum_last_d;
  logic                        sum_ovf_q, sum_ovf_d;

  logic                        last_term;
  logic                        accept;
  logic                        close_row;
  logic signed [ACC_WIDTH-1:0] total;
  logic signed [DOUT_WIDTH-1:0] clip_data;
  logic                        clip_ovf;

  assign sum_valid  = (state_q == ST_FULL);
  assign last_term  = (term_cnt_q == TCW'(N_TERMS - 1));
  // Stall only when the row would close into an occupied, unconsumed register
  assign prod_ready = !(last_term && sum_valid && !sum_ready);
  assign accept     = prod_valid && prod_ready;
  assign close_row  = accept && last_term;

  // Running sum: first term of a row restarts from zero
  assign total = ((term_cnt_q == '0) ? '0 : acc_q)
               + {{(ACC_WIDTH-DIN_WIDTH){prod_data[DIN_WIDTH-1]}}, prod_data};

  hls2x8_row_accum_clip #(
    .ACC_WIDTH  (ACC_WIDTH),
    .DOUT_WIDTH (DOUT_WIDTH)
  ) u_clip (
    .acc_in (total),
    .dout   (clip_data),
    .ovf    (clip_ovf)
  );

  // Next-state: counters, accumulator, output register and occupancy
  always_comb begin
    state_d    = state_q;
    term_cnt_d = term_cnt_q;
    row_cnt_d  = row_cnt_q;
    acc_d      = acc_q;
    sum_data_d = sum_data_q;
    sum_row_d  = sum_row_q;
    sum_last_d = sum_last_q;
    sum_ovf_d  = sum_ovf_q;
    if (close_row) begin
      sum_data_d = clip_data;
      sum_ovf_d  = clip_ovf;
      sum_row_d  = row_cnt_q;
      sum_last_d = (row_cnt_q == RW'(N_ROWS - 1));
      term_cnt_d = '0;
      row_cnt_d  = (row_cnt_q == RW'(N_ROWS - 1)) ? '0 : row_cnt_q + RW'(1);
    end else if (accept) begin
      acc_d      = total;
      term_cnt_d = term_cnt_q + TCW'(1);
    end
    case (state_q)
      ST_EMPTY: if (close_row) state_d = ST_FULL;
      ST_FULL:  if (sum_ready && !close_row) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // ---- register stage: all state, cleared by async reset ----
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q    <= ST_EMPTY;
      term_cnt_q <= '0;
      row_cnt_q  <= '0;
      acc_q      <= '0;
      sum_data_q <= '0;
      sum_row_q  <= '0;
      sum_last_q <= 1'b0;
      sum_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      term_cnt_q <= term_cnt_d;
      row_cnt_q  <= row_cnt_d;
      acc_q      <= acc_d;
      sum_data_q <= sum_data_d;
      sum_row_q  <= sum_row_d;
      sum_last_q <= sum_last_d;
      sum_ovf_q  <= sum_ovf_d;
    end
  end

  assign sum_data = sum_data_q;
  assign sum_row  = sum_row_q;
  assign sum_last = sum_last_q;
  assign sum_ovf  = sum_ovf_q;

endmodule

// File: tb/tb_hls2x8_row_accum.sv
// Directed bench for hls2x8_row_accum with default parameters.
// Expected clip results follow HLS2X8_ACC_SAT_EN as compiled.
module tb_hls2x8_row_accum;

  logic               ap_clk = 1'b0;
  logic               ap_rst;
  logic signed [15:0] prod_data;
  logic               prod_valid;
  logic               prod_ready;
  logic signed [15:0] sum_data;
  logic [0:0]         sum_row;
  logic               sum_last;
  logic               sum_ovf;
  logic               sum_valid;
  logic               sum_ready;

  int n_checks = 0;
  int n_errors = 0;

  bit mon_en = 1'b0;
  int mon_data[$];
  int mon_row[$];

  hls2x8_row_accum dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .prod_data  (prod_data),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .sum_data   (sum_data),
    .sum_row    (sum_row),
    .sum_last   (sum_last),
    .sum_ovf    (sum_ovf),
    .sum_valid  (sum_valid),
    .sum_ready  (sum_ready)
  );

  always #5 ap_clk = ~ap_clk;

  // Record every output handshake while monitoring is enabled
  always @(posedge ap_clk) begin
    if (mon_en && sum_valid && sum_ready) begin
      mon_data.push_back(int'(sum_data));
      mon_row.push_back(int'(sum_row));
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one product and hold it until accepted (inputs change #1 after edge)
  task automatic send(input int v);
    bit took;
    prod_data  = 16'(v);
    prod_valid = 1'b1;
    took = 1'b0;
    for (int i = 0; i < 50 && !took; i++) begin
      took = prod_ready;
      @(posedge ap_clk);
      #1;
    end
    if (!took) chk("send_timeout", 0, 1);
    prod_valid = 1'b0;
  endtask

  task automatic send_n(input int n, input int v);
    for (int i = 0; i < n; i++) send(v);
  endtask

  task automatic chk_out(input string tag, input int d, input int row, input int last);
    chk({tag, "_valid"}, int'(sum_valid), 1);
    chk({tag, "_data"},  int'(sum_data), d);
    chk({tag, "_row"},   int'(sum_row), row);
    chk({tag, "_last"},  int'(sum_last), last);
  endtask

  initial begin
    ap_rst     = 1'b1;
    prod_valid = 1'b0;
    prod_data  = '0;
    sum_ready  = 1'b1;
    repeat (3) @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    #1;
    chk("rst_prod_ready", int'(prod_ready), 1);
    chk("rst_sum_valid",  int'(sum_valid), 0);
    chk("rst_sum_data",   int'(sum_data), 0);
    chk("rst_sum_row",    int'(sum_row), 0);
    chk("rst_sum_last",   int'(sum_last), 0);
    chk("rst_sum_ovf",    int'(sum_ovf), 0);

    // Basic frame
    send_n(8, 3);
    chk_out("row0", 24, 0, 0);
    send_n(8, -5);
    chk_out("row1", -40, 1, 1);

    // Clipping, also shows row wrapping back to 0
    send_n(8, 16384);
`ifdef HLS2X8_ACC_SAT_EN
    chk_out("clip_pos", 32767, 0, 0);
    chk("clip_pos_ovf", int'(sum_ovf), 1);
`else
    chk_out("clip_pos", 0, 0, 0);
    chk("clip_pos_ovf", int'(sum_ovf), 0);
`endif
    send_n(8, -32768);
`ifdef HLS2X8_ACC_SAT_EN
    chk_out("clip_neg", -32768, 1, 1);
    chk("clip_neg_ovf", int'(sum_ovf), 1);
`else
    chk_out("clip_neg", 0, 1, 1);
    chk("clip_neg_ovf", int'(sum_ovf), 0);
`endif
    @(posedge ap_clk); #1;
    chk("drain_valid", int'(sum_valid), 0);

    // Backpressure
    send_n(8, 10);
    chk_out("bp_first", 80, 0, 0);
    sum_ready = 1'b0;
    send_n(7, 1);
    chk_out("bp_hold7", 80, 0, 0);
    prod_data  = 16'sd2;
    prod_valid = 1'b1;
    #1;
    chk("bp_stall_ready", int'(prod_ready), 0);
    @(posedge ap_clk); #1;
    chk("bp_stall_ready2", int'(prod_ready), 0);
    chk_out("bp_hold8", 80, 0, 0);
    sum_ready = 1'b1;
    #1;
    chk("bp_release_ready", int'(prod_ready), 1);
    @(posedge ap_clk); #1;
    sum_ready  = 1'b0;
    prod_valid = 1'b0;
    chk_out("bp_second", 9, 1, 1);
    sum_ready = 1'b1;
    @(posedge ap_clk); #1;
    chk("bp_drain_valid", int'(sum_valid), 0);

    // Reset in the middle of a row
    send_n(4, 100);
    ap_rst = 1'b1;
    #2 ap_rst = 1'b0;
    #1;
    chk("mid_rst_valid", int'(sum_valid), 0);
    chk("mid_rst_ready", int'(prod_ready), 1);
    send_n(8, 1);
    chk_out("after_rst", 8, 0, 0);
    @(posedge ap_clk); #1;

    // Idle gaps between products
    mon_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge ap_clk); #1;
      end
      send(1);
    end
    @(posedge ap_clk); #1;
    mon_en = 1'b0;
    chk("gap_count", mon_data.size(), 2);
    if (mon_data.size() == 2) begin
      chk("gap_d0", mon_data[0], 8);
      chk("gap_r0", mon_row[0], 1);
      chk("gap_d1", mon_data[1], 8);
      chk("gap_r1", mon_row[1], 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
